// File: rtl/bcd_stopwatch_2dig_if.sv
// Control/status bundle for bcd_stopwatch_2dig. The down input exists only when
// UPDOWN_EN is defined.
interface bcd_stopwatch_2dig_if;
   logic       start;
   logic       stop;
   logic       clear;
`ifdef UPDOWN_EN
   logic       down;
`endif
   logic [3:0] D0;
   logic [3:0] D1;
   logic       running;
   logic       tick;
   logic       ovf;

`ifdef UPDOWN_EN
   modport master (
      output start, stop, clear, down,
      input  D0, D1, running, tick, ovf
   );
   modport slave (
      input  start, stop, clear, down,
      output D0, D1, running, tick, ovf
   );
`else
   modport master (
      output start, stop, clear,
      input  D0, D1, running, tick, ovf
   );
   modport slave (
      input  start, stop, clear,
      output D0, D1, running, tick, ovf
   );
`endif
endinterface

// File: rtl/bcd_stopwatch_2dig.sv
// Two-digit BCD stopwatch (00-99) with a TICK_DIV prescaler and start/stop/clear control.
// Define UPDOWN_EN to add bus.down for BCD down counting with borrow.
module bcd_stopwatch_2dig #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter bit          WRAP     = 1'b1
) (
   input logic                 clk,
   input logic                 reset,
   bcd_stopwatch_2dig_if.slave bus
);
   localparam int unsigned   PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [3:0]    d0_q, d0_d;
   logic [3:0]    d1_q, d1_d;
   logic          ovf_q, ovf_d;
   logic          tick;
   logic          down;
   logic          at_end;

`ifdef UPDOWN_EN
   assign down = bus.down;
`else
   assign down = 1'b0;
`endif

   // Reset is folded in so a step discarded by reset never shows as a tick.
   assign tick = (state_q == ST_RUN) && (pre_q == PRE_LAST) &&
                 !bus.stop && !bus.clear && !reset;

   assign at_end = down ? ((d1_q == 4'd0) && (d0_q == 4'd0))
                        : ((d1_q == 4'd9) && (d0_q == 4'd9));

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      d0_d    = d0_q;
      d1_d    = d1_q;
      ovf_d   = 1'b0;
      if (bus.clear) begin
         state_d = ST_IDLE;
         pre_d   = '0;
         d0_d    = 4'd0;
         d1_d    = 4'd0;
      end else if (bus.stop) begin
         if (state_q == ST_RUN) state_d = ST_PAUSE;
      end else if (bus.start && (state_q != ST_RUN)) begin
         // Resuming keeps the held prescaler value.
         state_d = ST_RUN;
      end else if (tick) begin
         pre_d = '0;
         if (at_end) begin
            ovf_d = 1'b1;
            if (WRAP) begin
               d0_d = down ? 4'd9 : 4'd0;
               d1_d = down ? 4'd9 : 4'd0;
            end else begin
               state_d = ST_PAUSE;
            end
         end else if (down) begin
            if (d0_q == 4'd0) begin
               d0_d = 4'd9;
               d1_d = d1_q - 4'd1;
            end else begin
               d0_d = d0_q - 4'd1;
            end
         end else begin
            if (d0_q == 4'd9) begin
               d0_d = 4'd0;
               d1_d = d1_q + 4'd1;
            end else begin
               d0_d = d0_q + 4'd1;
            end
         end
      end else if (state_q == ST_RUN) begin
         pre_d = pre_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         d0_q    <= 4'd0;
         d1_q    <= 4'd0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.D0      = d0_q;
   assign bus.D1      = d1_q;
   assign bus.running = (state_q == ST_RUN);
   assign bus.tick    = tick;
   assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_bcd_stopwatch_2dig.sv
// Self-checking bench: a wrapping and a saturating stopwatch share one stimulus stream and are
// compared every cycle against an integer-count reference model.
module tb_bcd_stopwatch_2dig;
   localparam int TD    = 4;
   localparam int IDLE  = 0;
   localparam int RUN   = 1;
   localparam int PAUSE = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bcd_stopwatch_2dig_if if_w ();
   bcd_stopwatch_2dig_if if_s ();

   bcd_stopwatch_2dig #(.TICK_DIV(TD), .WRAP(1'b1)) dut_w (
      .clk   (clk),
      .reset (reset),
      .bus   (if_w.slave)
   );
   bcd_stopwatch_2dig #(.TICK_DIV(TD), .WRAP(1'b0)) dut_s (
      .clk   (clk),
      .reset (reset),
      .bus   (if_s.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model index 0 wraps, index 1 saturates; the count is a plain integer 0..99.
   int m_state [2];
   int m_pre   [2];
   int m_cnt   [2];
   bit m_ovf   [2];

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_state[k] = IDLE;
         m_pre[k]   = 0;
         m_cnt[k]   = 0;
         m_ovf[k]   = 1'b0;
      end
   endtask

   task automatic model_edge(input bit rs, input bit st, input bit sp, input bit cl,
                             input bit dn);
      int nxt;
      for (int k = 0; k < 2; k++) begin
         m_ovf[k] = 1'b0;
         if (rs || cl) begin
            m_state[k] = IDLE;
            m_pre[k]   = 0;
            m_cnt[k]   = 0;
         end else if (sp) begin
            if (m_state[k] == RUN) m_state[k] = PAUSE;
         end else if (st && m_state[k] != RUN) begin
            m_state[k] = RUN;
         end else if (m_state[k] == RUN) begin
            if (m_pre[k] < TD - 1) begin
               m_pre[k]++;
            end else begin
               m_pre[k] = 0;
               nxt = dn ? m_cnt[k] - 1 : m_cnt[k] + 1;
               if (nxt < 0 || nxt > 99) begin
                  m_ovf[k] = 1'b1;
                  if (k == 0) m_cnt[k] = (nxt + 100) % 100;
                  else m_state[k] = PAUSE;
               end else begin
                  m_cnt[k] = nxt;
               end
            end
         end
      end
   endtask

   task automatic chk_outs(input string p, input int k, input logic [3:0] d0,
                           input logic [3:0] d1, input logic run, input logic ovf);
      chk({p, ".D0"}, 8'(d0), 8'(m_cnt[k] % 10));
      chk({p, ".D1"}, 8'(d1), 8'(m_cnt[k] / 10));
      chk({p, ".running"}, 8'(run), 8'(m_state[k] == RUN));
      chk({p, ".ovf"}, 8'(ovf), 8'(m_ovf[k]));
   endtask

   // One clock: drive after negedge, check tick mid-cycle, check registered outputs after posedge.
   task automatic step(input bit rs, input bit st, input bit sp, input bit cl, input bit dn);
      @(negedge clk);
      reset      = rs;
      if_w.start = st;  if_s.start = st;
      if_w.stop  = sp;  if_s.stop  = sp;
      if_w.clear = cl;  if_s.clear = cl;
`ifdef UPDOWN_EN
      if_w.down  = dn;  if_s.down  = dn;
`endif
      #1;
      chk("wrap.tick", 8'(if_w.tick),
          8'(!rs && !cl && !sp && m_state[0] == RUN && m_pre[0] == TD - 1));
      chk("sat.tick", 8'(if_s.tick),
          8'(!rs && !cl && !sp && m_state[1] == RUN && m_pre[1] == TD - 1));
      @(posedge clk);
      model_edge(rs, st, sp, cl, dn);
      #1;
      chk_outs("wrap", 0, if_w.D0, if_w.D1, if_w.running, if_w.ovf);
      chk_outs("sat", 1, if_s.D0, if_s.D1, if_s.running, if_s.ovf);
   endtask

   initial begin
      bit r_rs, r_st, r_sp, r_cl, r_dn;
      reset      = 1'b1;
      if_w.start = 1'b0;  if_s.start = 1'b0;
      if_w.stop  = 1'b0;  if_s.stop  = 1'b0;
      if_w.clear = 1'b0;  if_s.clear = 1'b0;
`ifdef UPDOWN_EN
      if_w.down  = 1'b0;  if_s.down  = 1'b0;
`endif
      repeat (3) @(posedge clk);
      model_reset();

      step(1, 0, 0, 0, 0);
      repeat (8) step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      // Up to the tick cycle at count 05, then stop inside it.
      for (int i = 0; i < 100 && !(m_cnt[0] == 5 && m_state[0] == RUN && m_pre[0] == TD - 1);
           i++) step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      // Through 09->10 and on to the range end; start held high must be ignored in RUN.
      for (int i = 0; i < 600 && m_state[1] != PAUSE; i++) step(0, 1, 0, 0, 0);
      repeat (6) step(0, 0, 0, 0, 0);
      // Pause the wrapping unit at 42, then clear and start together.
      for (int i = 0; i < 400 && m_cnt[0] != 42; i++) step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      // Reset in the middle of a run.
      step(0, 1, 0, 0, 0);
      repeat (9) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
`ifdef UPDOWN_EN
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 100 && m_cnt[0] != 10; i++) step(0, 0, 0, 0, 0);
      for (int i = 0; i < 100 && m_cnt[0] != 0; i++) step(0, 0, 0, 0, 1);
      repeat (8) step(0, 0, 0, 0, 1);
`endif
      // Randomized control traffic biased toward long runs.
      for (int i = 0; i < 1500; i++) begin
         r_rs = ($urandom_range(127) == 0);
         r_cl = ($urandom_range(63) == 0);
         r_sp = ($urandom_range(15) == 0);
         r_st = ($urandom_range(3) == 0);
`ifdef UPDOWN_EN
         r_dn = ($urandom_range(1) == 1);
`else
         r_dn = 1'b0;
`endif
         step(r_rs, r_st, r_sp, r_cl, r_dn);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
